// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types and helpers for the registered scanning mux.
//                state_e      - controller state (MANUAL, SCAN, HOLD)
//                MODE_*       - encodings of the mode input
//                sel_width()  - select width for a given channel count
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_counter
//  Description : Counts clock cycles spent on one channel. done flags the
//                last dwell cycle of an enabled count; the counter then
//                rolls back to zero.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                clr  - synchronous clear to zero
//                en   - count enable; clr=0, en=0 freezes the count
//                done - count == DWELL-1 and en=1
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign done = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan
//  Description : Registered CH-channel multiplexer with manual select and
//                auto-scan modes. In scan mode each channel is sampled for
//                DWELL cycles; wrap pulses alongside the return to channel 0.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                mode      - 0 manual select, 1 auto-scan
//                hold      - freeze selection, dwell count and outputs
//                sel_in    - manual channel select
//                in        - channel data, channel k = in[k*W +: W]
//                ans       - registered sample of the selected channel
//                sel_out   - channel that ans was sampled from
//                ans_valid - ans holds a legal channel sample
//                wrap      - one-cycle pulse when scan returns to channel 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan
    import mux_pkg::*;
#(
    parameter int CH    = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    parameter int SELW  = sel_width(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic            hold,
    input  logic [SELW-1:0] sel_in,
    input  logic [CH*W-1:0] in,
    output logic [W-1:0]    ans,
    output logic [SELW-1:0] sel_out,
    output logic            ans_valid,
    output logic            wrap
);

    // Channel count widened by one bit so it is representable even when CH
    // is a power of two.
    localparam logic [SELW:0]   CH_EXT   = (SELW + 1)'(CH);
    localparam logic [SELW-1:0] LAST_SEL = SELW'(CH - 1);

    state_e          state;
    state_e          ret_state;
    logic [SELW-1:0] scan_sel;
    logic            wrap_pend;

    logic            active_scan;
    logic            manual_run;
    logic            prev_scan;
    logic            entry;
    logic [SELW-1:0] cur_sel;
    logic [SELW-1:0] next_sel;
    logic            legal;
    logic [W-1:0]    ch_data;
    logic            done;

    always_comb begin
        active_scan = !hold && (mode == MODE_SCAN);
        manual_run  = !hold && (mode == MODE_MANUAL);
        // Scan continues only if the previous non-held cycle was scanning;
        // otherwise this is the first scan cycle and starts at channel 0.
        prev_scan   = (state == SCAN) || ((state == HOLD) && (ret_state == SCAN));
        entry       = active_scan && !prev_scan;

        if (mode == MODE_SCAN) begin
            cur_sel = entry ? '0 : scan_sel;
        end else begin
            cur_sel = sel_in;
        end

        legal    = ({1'b0, cur_sel} < CH_EXT);
        next_sel = (cur_sel == LAST_SEL) ? '0 : cur_sel + 1'b1;

        // Explicit compare per channel keeps an illegal select from ever
        // forming an out-of-range slice.
        ch_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (int'(cur_sel) == k) begin
                ch_data = in[k*W +: W];
            end
        end
    end

    // The dwell count is cleared in manual mode, so every scan entry starts
    // with a full dwell on channel 0.
    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (manual_run),
        .en   (active_scan),
        .done (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MANUAL;
            ret_state <= MANUAL;
            scan_sel  <= '0;
            wrap_pend <= 1'b0;
            ans       <= '0;
            sel_out   <= '0;
            ans_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (hold) begin
            state <= HOLD;
            if (state != HOLD) begin
                ret_state <= state;
            end
            wrap <= 1'b0;
        end else if (mode == MODE_SCAN) begin
            state     <= SCAN;
            ans       <= ch_data;
            sel_out   <= cur_sel;
            ans_valid <= 1'b1;
            // The wrap decided on the last dwell cycle of CH-1 is emitted
            // together with the first channel-0 sample.
            wrap      <= wrap_pend;
            wrap_pend <= done && (cur_sel == LAST_SEL);
            scan_sel  <= done ? next_sel : cur_sel;
        end else begin
            state     <= MANUAL;
            wrap      <= 1'b0;
            wrap_pend <= 1'b0;
            if (legal) begin
                ans       <= ch_data;
                sel_out   <= cur_sel;
                ans_valid <= 1'b1;
            end else begin
                ans_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
